param_seq_detector: RTL and testbench

Parametrised serial pattern detector. It generalises the fixed 3-state detector FSM to a programmable pattern of PAT_LEN bits. Features: input-valid qualification, selectable overlapping/non-overlapping match mode, and a saturating match counter. It sits on a serial bit stream and flags each occurrence of the loaded pattern to downstream control logic.

---
 rtl/param_seq_detector.sv | 107 ++++++++++
 tb/tb_param_seq_detector.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_seq_detector.sv
// Programmable serial pattern detector.
// Flags each occurrence of a loaded PAT_LEN-bit pattern in a qualified
// serial stream. Overlapping and non-overlapping matching are both
// supported. A saturating counter tracks the number of matches.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | after reset; input stream ignored, waiting for first load
// HUNT  | pattern loaded; every valid bit is shifted in and compared
module param_seq_detector #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [PAT_LEN-1:0] pattern,
    input  logic               overlap,
    input  logic               in_valid,
    input  logic               in,
    input  logic               clear,
    output logic               armed,
    output logic               match,
    output logic [CNT_W-1:0]   match_count
);

    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic {
        IDLE = 1'b0,
        HUNT = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [PAT_LEN-1:0] pat_q, pat_nxt;
    logic               ovl_q, ovl_nxt;
    logic [PAT_LEN-1:0] hist, hist_nxt, hist_shift;
    logic [FILL_W-1:0]  fill, fill_nxt, fill_inc;
    logic               hit;
    logic [CNT_W-1:0]   cnt_nxt;

    // State, pattern/history registers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pat_q       <= '0;
            ovl_q       <= 1'b0;
            hist        <= '0;
            fill        <= '0;
            match       <= 1'b0;
            match_count <= '0;
        end else begin
            state       <= state_nxt;
            pat_q       <= pat_nxt;
            ovl_q       <= ovl_nxt;
            hist        <= hist_nxt;
            fill        <= fill_nxt;
            match       <= hit;
            match_count <= cnt_nxt;
        end
    end

    // Next-state, history shift, hit detection and counter update.
    // fill counts valid bits in the current window (saturating at PAT_LEN)
    // so that stale history can never produce a match.
    always_comb begin
        state_nxt  = state;
        pat_nxt    = pat_q;
        ovl_nxt    = ovl_q;
        hist_nxt   = hist;
        fill_nxt   = fill;
        hit        = 1'b0;
        cnt_nxt    = match_count;
        hist_shift = {hist[PAT_LEN-2:0], in};
        fill_inc   = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);

        if (load) begin
            // The bit presented alongside load is discarded.
            state_nxt = HUNT;
            pat_nxt   = pattern;
            ovl_nxt   = overlap;
            hist_nxt  = '0;
            fill_nxt  = '0;
        end else if (state == HUNT && in_valid) begin
            hit      = (fill_inc == FILL_FULL) && (hist_shift == pat_q);
            hist_nxt = hist_shift;
            fill_nxt = fill_inc;
            if (hit && !ovl_q) begin
                // Non-overlapping: the next match needs a full fresh window.
                hist_nxt = '0;
                fill_nxt = '0;
            end
        end

        // Clear beats a simultaneous hit; the match pulse still fires.
        if (clear) begin
            cnt_nxt = '0;
        end else if (hit && (match_count != CNT_MAX)) begin
            cnt_nxt = match_count + CNT_W'(1);
        end
    end

    assign armed = (state == HUNT);

endmodule

// File: tb/tb_param_seq_detector.sv
// Self-checking bench for param_seq_detector: a directed vector table,
// hand-written corner sequences and a randomized run checked against a
// queue-based reference model. Two instances differ only in counter width.
module tb_param_seq_detector;

    localparam int PL = 4;

    logic          clk;
    logic          reset;
    logic          load;
    logic [PL-1:0] pattern;
    logic          overlap;
    logic          in_valid;
    logic          din;
    logic          clear;

    logic          armed8, match8;
    logic [7:0]    cnt8;
    logic          armed2, match2;
    logic [1:0]    cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    param_seq_detector #(.PAT_LEN(PL), .CNT_W(8)) u_dut8 (
        .clk(clk), .reset(reset), .load(load), .pattern(pattern),
        .overlap(overlap), .in_valid(in_valid), .in(din), .clear(clear),
        .armed(armed8), .match(match8), .match_count(cnt8)
    );

    param_seq_detector #(.PAT_LEN(PL), .CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .load(load), .pattern(pattern),
        .overlap(overlap), .in_valid(in_valid), .in(din), .clear(clear),
        .armed(armed2), .match(match2), .match_count(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the valid bits of the current window kept in a queue.
    bit          m_armed;
    bit          m_ovl;
    bit [PL-1:0] m_pat;
    bit          m_q[$];
    bit          m_match;
    int          m_cnt8;
    int          m_cnt2;

    function automatic void model_reset();
        m_armed = 1'b0;
        m_ovl   = 1'b0;
        m_pat   = '0;
        m_q.delete();
        m_match = 1'b0;
        m_cnt8  = 0;
        m_cnt2  = 0;
    endfunction

    function automatic void model_edge();
        bit hit = 1'b0;
        int v   = 0;
        if (!reset) begin
            model_reset();
            return;
        end
        if (load) begin
            m_armed = 1'b1;
            m_pat   = pattern;
            m_ovl   = overlap;
            m_q.delete();
        end else if (m_armed && in_valid) begin
            m_q.push_back(din);
            if (m_q.size() > PL) void'(m_q.pop_front());
            if (m_q.size() == PL) begin
                foreach (m_q[i]) v = v * 2 + int'(m_q[i]);
                hit = (v == int'(m_pat));
            end
            if (hit && !m_ovl) m_q.delete();
        end
        m_match = hit;
        if (clear) begin
            m_cnt8 = 0;
            m_cnt2 = 0;
        end else if (hit) begin
            m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
            m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("armed8", int'(armed8), int'(m_armed));
        chk("match8", int'(match8), int'(m_match));
        chk("count8", int'(cnt8), m_cnt8);
        chk("armed2", int'(armed2), int'(m_armed));
        chk("match2", int'(match2), int'(m_match));
        chk("count2", int'(cnt2), m_cnt2);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input bit l, input bit [PL-1:0] p, input bit o,
                         input bit v, input bit d, input bit c);
        load     = l;
        pattern  = p;
        overlap  = o;
        in_valid = v;
        din      = d;
        clear    = c;
    endtask

    typedef struct {
        bit          load;
        bit [PL-1:0] pat;
        bit          ovl;
        bit          vld;
        bit          din;
        bit          clr;
        bit          e_armed;
        bit          e_match;
        int          e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit l, bit [PL-1:0] p, bit o, bit v, bit d,
                                bit c, bit ea, bit em, int ec);
        vec_t r;
        r.load = l; r.pat = p; r.ovl = o; r.vld = v; r.din = d; r.clr = c;
        r.e_armed = ea; r.e_match = em; r.e_cnt = ec;
        vecs.push_back(r);
    endfunction

    initial begin
        bit [15:0] sat_stream;

        // Test 1: bits without a load are ignored.
        add(0, 4'b0000, 0, 1, 1, 0, 0, 0, 0);
        add(0, 4'b0000, 0, 1, 0, 0, 0, 0, 0);
        add(0, 4'b0000, 0, 1, 1, 0, 0, 0, 0);
        add(0, 4'b0000, 0, 1, 1, 0, 0, 0, 0);
        // Test 2: overlapping, 1011 in 1,0,1,1,0,1,1.
        add(1, 4'b1011, 1, 0, 0, 1, 1, 0, 0);
        add(0, 4'b0000, 0, 1, 1, 0, 1, 0, 0);
        add(0, 4'b0000, 0, 1, 0, 0, 1, 0, 0);
        add(0, 4'b0000, 0, 1, 1, 0, 1, 0, 0);
        add(0, 4'b0000, 0, 1, 1, 0, 1, 1, 1);
        add(0, 4'b0000, 0, 1, 0, 0, 1, 0, 1);
        add(0, 4'b0000, 0, 1, 1, 0, 1, 0, 1);
        add(0, 4'b0000, 0, 1, 1, 0, 1, 1, 2);
        // Test 3: non-overlapping, then a fresh 1,0,1,1.
        add(1, 4'b1011, 0, 0, 0, 1, 1, 0, 0);
        add(0, 4'b0000, 0, 1, 1, 0, 1, 0, 0);
        add(0, 4'b0000, 0, 1, 0, 0, 1, 0, 0);
        add(0, 4'b0000, 0, 1, 1, 0, 1, 0, 0);
        add(0, 4'b0000, 0, 1, 1, 0, 1, 1, 1);
        add(0, 4'b0000, 0, 1, 0, 0, 1, 0, 1);
        add(0, 4'b0000, 0, 1, 1, 0, 1, 0, 1);
        add(0, 4'b0000, 0, 1, 1, 0, 1, 0, 1);
        add(0, 4'b0000, 0, 1, 1, 0, 1, 0, 1);
        add(0, 4'b0000, 0, 1, 0, 0, 1, 0, 1);
        add(0, 4'b0000, 0, 1, 1, 0, 1, 0, 1);
        add(0, 4'b0000, 0, 1, 1, 0, 1, 1, 2);
        // Test 4: in_valid gaps with noise, then load mid-stream.
        add(1, 4'b1011, 1, 0, 0, 1, 1, 0, 0);
        add(0, 4'b0000, 0, 1, 1, 0, 1, 0, 0);
        add(0, 4'b0000, 0, 0, 0, 0, 1, 0, 0);
        add(0, 4'b0000, 0, 1, 0, 0, 1, 0, 0);
        add(0, 4'b0000, 0, 0, 1, 0, 1, 0, 0);
        add(0, 4'b0000, 0, 1, 1, 0, 1, 0, 0);
        add(0, 4'b0000, 0, 0, 0, 0, 1, 0, 0);
        add(0, 4'b0000, 0, 1, 1, 0, 1, 1, 1);
        add(0, 4'b0000, 0, 0, 1, 0, 1, 0, 1);
        add(0, 4'b0000, 0, 1, 1, 0, 1, 0, 1);
        add(0, 4'b0000, 0, 1, 0, 0, 1, 0, 1);
        add(0, 4'b0000, 0, 1, 1, 0, 1, 0, 1);
        add(1, 4'b1011, 1, 1, 1, 0, 1, 0, 1);
        add(0, 4'b0000, 0, 1, 1, 0, 1, 0, 1);

        model_reset();
        reset = 1'b0;
        drive(0, '0, 0, 0, 0, 0);
        #1;
        compare_all();
        step();
        step();
        reset = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].load, vecs[i].pat, vecs[i].ovl, vecs[i].vld,
                  vecs[i].din, vecs[i].clr);
            step();
            chk($sformatf("tbl%0d_armed", i), int'(armed8), int'(vecs[i].e_armed));
            chk($sformatf("tbl%0d_match", i), int'(match8), int'(vecs[i].e_match));
            chk($sformatf("tbl%0d_count", i), int'(cnt8), vecs[i].e_cnt);
        end

        // Test 5: saturation of the 2-bit counter, and clear against a hit.
        drive(1, 4'b1011, 1, 0, 0, 1);
        step();
        sat_stream = 16'b1011011011011011;
        for (int i = 15; i >= 0; i--) begin
            drive(0, '0, 0, 1, sat_stream[i], 0);
            step();
        end
        chk("sat_count2", int'(cnt2), 3);
        chk("sat_count8", int'(cnt8), 5);
        drive(0, '0, 0, 1, 0, 0);
        step();
        drive(0, '0, 0, 1, 1, 0);
        step();
        drive(0, '0, 0, 1, 1, 1);
        step();
        chk("clr_hit_match8", int'(match8), 1);
        chk("clr_hit_match2", int'(match2), 1);
        chk("clr_hit_count8", int'(cnt8), 0);
        chk("clr_hit_count2", int'(cnt2), 0);

        // Test 6: asynchronous reset while match is high.
        drive(1, 4'b1011, 1, 0, 0, 0);
        step();
        drive(0, '0, 0, 1, 1, 0); step();
        drive(0, '0, 0, 1, 0, 0); step();
        drive(0, '0, 0, 1, 1, 0); step();
        drive(0, '0, 0, 1, 1, 0); step();
        chk("pre_rst_match", int'(match8), 1);
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("async_rst_armed", int'(armed8), 0);
        chk("async_rst_match", int'(match8), 0);
        chk("async_rst_count", int'(cnt8), 0);
        #2;
        reset = 1'b1;
        drive(0, '0, 0, 1, 1, 0); step();
        drive(0, '0, 0, 1, 0, 0); step();
        drive(0, '0, 0, 1, 1, 0); step();
        drive(0, '0, 0, 1, 1, 0); step();
        chk("post_rst_armed", int'(armed8), 0);
        chk("post_rst_match", int'(match8), 0);

        // Randomized run against the reference model.
        drive(1, PL'($urandom), 1'($urandom), 0, 0, 0);
        step();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 19) == 0, PL'($urandom), 1'($urandom),
                  $urandom_range(0, 3) != 0, 1'($urandom),
                  $urandom_range(0, 29) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
